seq_div_2w_by_w: RTL

//  Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient, W-bit remainder.

---
 rtl/seq_div_2w_by_w_if.sv | 24 ++
 rtl/seq_div_2w_by_w.sv | 115 +++++++++++
 2 files changed

// File: rtl/seq_div_2w_by_w_if.sv
// Operand/result handshake bundle for the sequential 2W/W divider.
// slave is the divider side, master is the producer/consumer side.
interface seq_div_2w_by_w_if #(parameter int W = 8);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;
  logic           div_zero;
  logic           ovf;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quot, rem, div_zero, ovf
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quot, rem, div_zero, ovf
  );
endinterface

// File: rtl/seq_div_2w_by_w.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
module seq_div_2w_by_w #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_div_2w_by_w_if.slave bus
);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   r_q, r_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   quot_q, quot_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           dz_q, dz_d;
  logic           ovf_q, ovf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     r_sh;

  // Partial remainder stays below the divisor between steps, so W bits of
  // storage suffice; only the shifted value needs the extra bit.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    r_sh    = {r_q, lo_q[W-1]};
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          lo_d  = bus.dividend[W-1:0];
          dvs_d = bus.divisor;
          r_d   = bus.dividend[2*W-1:W];
          cnt_d = '0;
          dz_d  = 1'b0;
          ovf_d = 1'b0;
          if (bus.divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = bus.dividend[W-1:0];
            dz_d    = 1'b1;
          end else if (bus.dividend[2*W-1:W] >= bus.divisor) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = '0;
            ovf_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        lo_d  = lo_q << 1;
        cnt_d = cnt_q + 1'b1;
        // True difference is < 2^W, so modular W-bit subtraction is exact.
        if (r_sh >= {1'b0, dvs_q}) begin
          r_d    = r_sh[W-1:0] - dvs_q;
          quot_d = {quot_q[W-2:0], 1'b1};
        end else begin
          r_d    = r_sh[W-1:0];
          quot_d = {quot_q[W-2:0], 1'b0};
        end
        if (cnt_q == CW'(W-1)) begin
          state_d = DONE;
          rem_d   = r_d;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quot      = quot_q;
  assign bus.rem       = rem_q;
  assign bus.div_zero  = dz_q;
  assign bus.ovf       = ovf_q;
endmodule
